// File: rtl/ysyx_22040759_ifu.sv
// ysyx_22040759_ifu -- multi-cycle instruction fetch unit.
//
// Owns the fetch PC and issues word requests to instruction memory over a
// valid/ready channel. Responses come back in order, one or more cycles
// later, and are always accepted. Fetched words land in a DEPTH-entry
// registered queue (no bypass) and are handed to decode through a
// valid/ready handshake.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   req_valid/ready/addr fetch request channel (req_addr = fetch PC)
//   resp_valid/data      in-order response for the oldest outstanding request
//   inst_valid/ready     decode handshake on the queue head
//   inst, inst_pc        head instruction word and its PC (0 when invalid)
//   redirect_valid/pc    new PC from execute; flushes queue, drops in-flight
//   halt                 stop issuing requests (ebreak)
//   fetch_misalign       misaligned-redirect trap pending
//   misalign_pc          offending redirect target
//
// Optional feature: define YSYX_22040759_IFU_MISALIGN_TRAP_EN to trap on a
// redirect target with nonzero low bits. Without it the low two bits are
// cleared, the trap state is unreachable and the trap outputs are tied 0.
module ysyx_22040759_ifu #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [31:0]     resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            fetch_misalign,
  output logic [XLEN-1:0] misalign_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, TRAP = 2'd2} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding, drop_cnt, count;
  logic [XLEN-1:0] tgt;
  logic            misalign;
  logic            credit_ok, req_hs, push, pop;

  // ---- redirect target -------------------------------------------------
`ifdef YSYX_22040759_IFU_MISALIGN_TRAP_EN
  assign tgt      = redirect_pc;
  assign misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
  assign tgt      = redirect_pc & ~XLEN'(3);
  assign misalign = 1'b0;
`endif

  // ---- FSM -------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Redirect wins over halt in the same cycle.
  always_comb begin
    state_d = state_q;
    if (redirect_valid)                 state_d = misalign ? TRAP : RUN;
    else if (halt && state_q == RUN)    state_d = HALT;
  end

  // Credit: every issued request must already own a queue slot, so
  // responses never need back-pressure. Dropped-but-pending responses still
  // hold credit until they return. rst gates issue while reset is held.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(DEPTH);

  always_comb begin
    req_valid = 1'b0;
    if (rst && state_q == RUN && !redirect_valid && credit_ok) req_valid = 1'b1;
  end

  assign req_addr = fetch_pc;
  assign req_hs   = req_valid & req_ready;

  // ---- fetch PC ----------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= tgt;
    else if (req_hs)         fetch_pc <= fetch_pc + XLEN'(4);
  end

  // ---- in-flight tracking ----------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) outstanding <= '0;
    else      outstanding <= outstanding + CW'(req_hs) - CW'(resp_valid);
  end

  // On redirect every request still unreturned after this cycle is stale;
  // that set already contains anything an earlier redirect marked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              drop_cnt <= '0;
    else if (redirect_valid)               drop_cnt <= outstanding - CW'(resp_valid);
    else if (resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
  end

  // PC of each issued request, popped as its response returns (dropped or
  // not), so the head always pairs with the current response.
  logic [XLEN-1:0] pcq [DEPTH];
  logic [AW-1:0]   pq_wr, pq_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pq_wr <= '0;
      pq_rd <= '0;
    end else begin
      if (req_hs)     pq_wr <= pq_wr + AW'(1);
      if (resp_valid) pq_rd <= pq_rd + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (req_hs) pcq[pq_wr] <= fetch_pc;
  end

  // ---- instruction queue -----------------------------------------------
  entry_t        q_mem [DEPTH];
  logic [AW-1:0] q_wr, q_rd;
  entry_t        head;

  assign push = resp_valid & (drop_cnt == '0) & ~redirect_valid;
  assign pop  = inst_valid & inst_ready & ~redirect_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_wr  <= '0;
      q_rd  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      q_wr  <= '0;
      q_rd  <= '0;
      count <= '0;
    end else begin
      if (push) q_wr <= q_wr + AW'(1);
      if (pop)  q_rd <= q_rd + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[q_wr] <= {pcq[pq_rd], resp_data};
  end

  // Storage is not reset; outputs are masked to 0 while the queue is empty.
  assign head       = q_mem[q_rd];
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? head.inst : 32'd0;
  assign inst_pc    = inst_valid ? head.pc   : '0;

  // ---- misaligned-redirect trap ----------------------------------------
`ifdef YSYX_22040759_IFU_MISALIGN_TRAP_EN
  logic            fm_q;
  logic [XLEN-1:0] mpc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fm_q  <= 1'b0;
      mpc_q <= '0;
    end else if (redirect_valid) begin
      fm_q  <= misalign;
      mpc_q <= misalign ? redirect_pc : '0;
    end
  end

  assign fetch_misalign = fm_q;
  assign misalign_pc    = mpc_q;
`else
  assign fetch_misalign = 1'b0;
  assign misalign_pc    = '0;
`endif

endmodule

// File: tb/tb_ysyx_22040759_ifu.sv
module tb_ysyx_22040759_ifu;
  localparam int DEPTH = 4;
  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data  = '0;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid, halt, fetch_misalign;
  logic [63:0] redirect_pc, misalign_pc;

  int total = 0;
  int bad   = 0;

  ysyx_22040759_ifu #(.XLEN(64), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .fetch_misalign(fetch_misalign), .misalign_pc(misalign_pc)
  );

  always #5 clk = ~clk;

  // ---- memory model: in-order, latency lat (or random 1..3), data = ~addr
  typedef struct { logic [63:0] a; int due; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] ins; } ent_t;
  mreq_t       mq[$];
  logic [63:0] reqlog[$];
  ent_t        outlog[$];
  int          cyc;
  int          lat = 1;
  bit          rand_lat = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      cyc <= 0;
    end else begin
      if (resp_valid) mq.pop_front();
      if (req_valid && req_ready) begin
        mq.push_back('{a: req_addr, due: cyc + (rand_lat ? int'($urandom_range(1, 3)) : lat)});
        reqlog.push_back(req_addr);
      end
      if (inst_valid && inst_ready) outlog.push_back('{pc: inst_pc, ins: inst});
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      resp_valid <= 1'b1;
      resp_data  <= ~mq[0].a[31:0];
    end else begin
      resp_valid <= 1'b0;
    end
  end

  // Holds reset two cycles, releases at a negedge: caller is then in cycle 0.
  task automatic do_reset();
    rst = 1'b0; req_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; halt = 1'b0; lat = 1; rand_lat = 1'b0;
    repeat (2) @(negedge clk);
    reqlog.delete();
    outlog.delete();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_ready = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = '0; halt = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    total++; if (req_addr !== RPC) begin bad++; $display("FAIL reset_req_addr: got %h want %h", req_addr, RPC); end
    total++; if (inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 64'd0) begin
      bad++; $display("FAIL reset_inst: got v=%b inst=%h pc=%h want 0/0/0", inst_valid, inst, inst_pc); end
    total++; if (fetch_misalign !== 1'b0 || misalign_pc !== 64'd0) begin
      bad++; $display("FAIL reset_misalign: got %b %h want 0 0", fetch_misalign, misalign_pc); end
    rst = 1'b1;
    #1;
    total++; if (req_valid !== 1'b1 || req_addr !== RPC) begin
      bad++; $display("FAIL reset_first_req: got v=%b a=%h want 1 %h", req_valid, req_addr, RPC); end
  endtask

  task automatic test_stream();
    int first = -1;
    int vcount = 0;
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (inst_valid) begin
        vcount++;
        if (first < 0) begin
          first = c;
          total++; if (inst_pc !== RPC) begin bad++; $display("FAIL stream_first_pc: got %h want %h", inst_pc, RPC); end
        end
      end
    end
    total++; if (first != 2) begin bad++; $display("FAIL stream_latency: got %0d want 2", first); end
    total++; if (vcount != 21) begin bad++; $display("FAIL stream_throughput: got %0d want 21", vcount); end
    total++; if (outlog.size() != 20) begin bad++; $display("FAIL stream_count: got %0d want 20", outlog.size()); end
    for (int i = 0; i < outlog.size(); i++) begin
      logic [63:0] e;
      e = RPC + 64'(4 * i);
      total++;
      if (outlog[i].pc !== e || outlog[i].ins !== ~e[31:0]) begin
        bad++; $display("FAIL stream_seq[%0d]: got %h/%h want %h/%h", i, outlog[i].pc, outlog[i].ins, e, ~e[31:0]);
      end
    end
  endtask

  task automatic test_stall();
    bit changed = 1'b0;
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b0; lat = 1;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (!inst_valid || inst_pc !== RPC || inst !== ~RPC[31:0]) changed = 1'b1;
    end
    total++; if (reqlog.size() != DEPTH) begin bad++; $display("FAIL stall_reqs: got %0d want %0d", reqlog.size(), DEPTH); end
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid: got %b want 0", req_valid); end
    total++; if (changed) begin bad++; $display("FAIL stall_head_hold: head changed or dropped, want stable %h", RPC); end
    inst_ready = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (outlog.size() < 12) begin bad++; $display("FAIL stall_resume: got %0d want >=12", outlog.size()); end
    for (int i = 0; i < outlog.size(); i++) begin
      logic [63:0] e;
      e = RPC + 64'(4 * i);
      total++;
      if (outlog[i].pc !== e || outlog[i].ins !== ~e[31:0]) begin
        bad++; $display("FAIL stall_seq[%0d]: got %h want %h", i, outlog[i].pc, e);
      end
    end
  endtask

  // Two requests in flight (latency 3), redirect; optional second redirect
  // while the first drop is still in progress.
  task automatic test_redirect(input bit twice);
    logic [63:0] base;
    base = twice ? 64'h8000_2000 : 64'h8000_1000;
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b1; lat = 3;
    repeat (2) @(negedge clk);                       // cycle 2
    req_ready = 1'b0;
    total++; if (reqlog.size() != 2) begin bad++; $display("FAIL redir_inflight: got %0d want 2", reqlog.size()); end
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    #1;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL redir_req_blocked: got %b want 0", req_valid); end
    @(negedge clk);                                  // cycle 3
    redirect_valid = 1'b0; req_ready = 1'b1;
    #1;
    total++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_1000) begin
      bad++; $display("FAIL redir_first_req: got v=%b a=%h want 1 80001000", req_valid, req_addr); end
    if (twice) begin
      @(negedge clk);                                // cycle 4
      redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
      @(negedge clk);                                // cycle 5
      redirect_valid = 1'b0;
      #1;
      total++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_2000) begin
        bad++; $display("FAIL redir2_first_req: got v=%b a=%h want 1 80002000", req_valid, req_addr); end
    end
    repeat (15) @(negedge clk);
    total++; if (outlog.size() < 4) begin bad++; $display("FAIL redir_delivered: got %0d want >=4", outlog.size()); end
    for (int i = 0; i < outlog.size(); i++) begin
      logic [63:0] e;
      e = base + 64'(4 * i);
      total++;
      if (outlog[i].pc !== e || outlog[i].ins !== ~e[31:0]) begin
        bad++; $display("FAIL redir_seq[%0d]: got %h want %h", i, outlog[i].pc, e);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b1; lat = 3;
    repeat (3) @(negedge clk);                       // cycle 3: 3 in flight
    req_ready = 1'b0; halt = 1'b1;
    @(negedge clk);
    halt = 1'b0; req_ready = 1'b1;
    repeat (12) @(negedge clk);
    total++; if (reqlog.size() != 3) begin bad++; $display("FAIL halt_reqs: got %0d want 3", reqlog.size()); end
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL halt_req_valid: got %b want 0", req_valid); end
    total++; if (outlog.size() != 3) begin bad++; $display("FAIL halt_drained: got %0d want 3", outlog.size()); end
    for (int i = 0; i < outlog.size(); i++) begin
      logic [63:0] e;
      e = RPC + 64'(4 * i);
      total++;
      if (outlog[i].pc !== e) begin bad++; $display("FAIL halt_seq[%0d]: got %h want %h", i, outlog[i].pc, e); end
    end
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    total++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_0100) begin
      bad++; $display("FAIL halt_restart: got v=%b a=%h want 1 80000100", req_valid, req_addr); end
    repeat (10) @(negedge clk);
    total++; if (outlog.size() < 4 || outlog[3].pc !== 64'h8000_0100) begin
      bad++; $display("FAIL halt_restart_pc: got n=%0d want entry 3 = 80000100", outlog.size()); end
  endtask

  task automatic test_random();
    do_reset();
    req_ready = 1'b1; rand_lat = 1'b1;
    for (int c = 0; c < 100; c++) begin
      inst_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    inst_ready = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (outlog.size() < 30) begin bad++; $display("FAIL rand_progress: got %0d want >=30", outlog.size()); end
    for (int i = 0; i < outlog.size(); i++) begin
      logic [63:0] e;
      e = RPC + 64'(4 * i);
      total++;
      if (outlog[i].pc !== e || outlog[i].ins !== ~e[31:0]) begin
        bad++; $display("FAIL rand_seq[%0d]: got %h/%h want %h/%h", i, outlog[i].pc, outlog[i].ins, e, ~e[31:0]);
      end
    end
  endtask

  task automatic test_misalign();
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
    repeat (3) @(negedge clk);                       // cycle 3, queue non-empty
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    outlog.delete();
    #1;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL mis_flush: got %b want 0", inst_valid); end
`ifdef YSYX_22040759_IFU_MISALIGN_TRAP_EN
    begin
      bit issued = 1'b0;
      total++; if (fetch_misalign !== 1'b1 || misalign_pc !== 64'h8000_0102) begin
        bad++; $display("FAIL mis_trap: got %b %h want 1 80000102", fetch_misalign, misalign_pc); end
      for (int c = 0; c < 5; c++) begin
        if (req_valid !== 1'b0) issued = 1'b1;
        @(negedge clk);
      end
      total++; if (issued) begin bad++; $display("FAIL mis_trap_noreq: got req_valid=1 want 0"); end
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      total++; if (fetch_misalign !== 1'b0 || req_valid !== 1'b1 || req_addr !== 64'h8000_0200) begin
        bad++; $display("FAIL mis_clear: got fm=%b v=%b a=%h want 0 1 80000200", fetch_misalign, req_valid, req_addr); end
    end
`else
    total++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_0100) begin
      bad++; $display("FAIL mis_aligned_req: got v=%b a=%h want 1 80000100", req_valid, req_addr); end
    total++; if (fetch_misalign !== 1'b0 || misalign_pc !== 64'd0) begin
      bad++; $display("FAIL mis_tied: got %b %h want 0 0", fetch_misalign, misalign_pc); end
    repeat (8) @(negedge clk);
    total++; if (outlog.size() < 3 || outlog[0].pc !== 64'h8000_0100 || outlog[2].pc !== 64'h8000_0108) begin
      bad++; $display("FAIL mis_aligned_seq: got n=%0d want 80000100,104,108...", outlog.size()); end
`endif
  endtask

  task automatic test_midreset();
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_pc !== 64'd0 || inst !== 32'd0) begin
      bad++; $display("FAIL midreset_clear: got v=%b iv=%b pc=%h i=%h want 0", req_valid, inst_valid, inst_pc, inst); end
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (inst_valid !== 1'b1 || inst_pc !== RPC) begin
      bad++; $display("FAIL midreset_restart: got v=%b pc=%h want 1 %h", inst_valid, inst_pc, RPC); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect(1'b0);
    test_redirect(1'b1);
    test_halt();
    test_random();
    test_misalign();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_22040759_ifu.md
# ysyx_22040759_ifu

Parametrised multi-cycle instruction fetch unit, the successor to the single-cycle PC/adder/inst-RAM path of the NPC. It owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with pipelined responses. Fetched instructions are buffered in a configurable-depth queue and handed to decode through a valid/ready handshake. It supports redirects (jump/branch), with flush and discard of in-flight responses, and a halt state for ebreak.

## Interface
- XLEN, 64: PC/address width.
- RESET_PC, 64'h8000_0000: first fetch address after reset.
- DEPTH, 4: instruction queue entries; power of two, ≥2; also the bound on in-flight plus buffered fetches.
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- req_valid  output  1  fetch request valid.
- req_ready  input  1  memory accepts request.
- req_addr  output  XLEN  word address of request.
- resp_valid  input  1  response for oldest outstanding request; always accepted.
- resp_data  input  32  instruction word.
- inst_valid  output  1  queue head valid.
- inst_ready  input  1  decode consumes head.
- inst  output  32  head instruction.
- inst_pc  output  XLEN  head instruction PC.
- redirect_valid  input  1  new PC from execute.
- redirect_pc  input  XLEN  redirect target.
- halt  input  1  stop fetching (ebreak).
- fetch_misalign  output  1  misaligned-redirect trap pending (see Configuration).
- misalign_pc  output  XLEN  offending target.

## Operation
- FSM states: RUN, HALT, TRAP. Reset state is RUN.
- Transitions:
  - RUN→HALT on halt.
  - RUN/HALT/TRAP→RUN on an aligned redirect.
  - Any→TRAP on a misaligned redirect (macro on only).
- Redirect has priority over halt in the same cycle.
- fetch_pc: register, reset RESET_PC. Increments by 4 on each req handshake. Loaded with redirect_pc on redirect.
- outstanding: counter, width $clog2(DEPTH)+1. Increments on req handshake. Decrements on each resp_valid.
- count: number of queue entries.
- req_valid = (state==RUN) & !redirect_valid & (outstanding + count < DEPTH). req_addr = fetch_pc.
- The credit rule guarantees queue space for every response; resp_valid is never back-pressured.
- Queue entries store {pc, inst}. The entry PC comes from a parallel PC queue written at request handshake time.
- Head pops on inst_valid & inst_ready. Simultaneous push and pop on a full queue is legal and count stays unchanged.
- Redirect:
  - Queue is flushed at that clock edge. inst_valid=0 from the next cycle.
  - drop_cnt is loaded with outstanding minus (resp_valid this cycle).
  - While drop_cnt>0, each resp_valid decrements drop_cnt and its data is discarded.
  - New requests may issue during drop.
  - A redirect arriving during drop adds the still-outstanding requests to drop_cnt.
- HALT: no new requests. Outstanding responses are still enqueued and drained to decode.
- Wrap-around: fetch_pc wraps modulo 2^XLEN. Queue pointers wrap modulo DEPTH.

## Timing
- Reset (async assert, sync deassert):
  - req_valid=0, req_addr=RESET_PC.
  - inst_valid=0, inst=0, inst_pc=0.
  - fetch_misalign=0, misalign_pc=0.
  - count, outstanding, drop_cnt all 0.
- Reset mid-operation discards all outstanding state. Memory is reset in the same domain.
- First req_valid is in the first cycle after rst deasserts.
- Request accepted cycle N, resp_valid cycle N+k (k≥1): inst_valid in cycle N+k+1 at earliest. This is a registered queue with no bypass.
- Redirect in cycle N: req_valid=0 in N. The first request to redirect_pc is presented in N+1.
- Back-to-back throughput: one instruction per cycle when k=1 and DEPTH≥2.
- inst and inst_pc stay stable while inst_valid & !inst_ready.

## Configuration
- YSYX_22040759_IFU_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0]!=0 enters TRAP.
  - fetch_misalign=1 and misalign_pc=redirect_pc, registered, visible next cycle.
  - No requests are issued in TRAP. The queue is flushed and in-flight responses are dropped.
  - The next aligned redirect clears the trap and returns to RUN.
- Undefined:
  - redirect_pc[1:0] is forced to 0 and TRAP is unreachable.
  - fetch_misalign and misalign_pc are tied to 0.

## Test plan
- Reset release, req_ready=1, 1-cycle memory returning addr-derived words, inst_ready=1 → inst_pc sequence 0x80000000, 0x80000004, … on consecutive cycles; first inst_valid 2 cycles after first request.
- inst_ready=0 with DEPTH=4 → at most 4 requests accepted, then req_valid=0; count=4; releasing inst_ready resumes issue.
- Redirect to 0x80001000 with 2 responses outstanding → both discarded; next inst_pc=0x80001000; no stale PC ever presented.
- halt while 3 fetches in flight → 3 instructions delivered, then no further req_valid; redirect to 0x80000100 restarts fetch at that PC.
- Simultaneous push and pop with full queue over 100 cycles of random inst_ready and random k in 1–3 → in-order PCs, none lost or duplicated.
- Macro on: redirect to 0x80000102 → fetch_misalign=1 and misalign_pc=0x80000102 next cycle, req_valid stays 0; redirect to 0x80000200 clears it. Macro off: same redirect fetches 0x80000100.
